// File: rtl/basic_sequencer.sv
// basic_sequencer: timing/control unit of the basic accumulator computer
module basic_sequencer #(
  parameter int ADDR_W       = 6,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W+3:0] ir,
  input  logic              dr_zero,
  input  logic              fgi,
  input  logic              fgo,
  output logic [7:0]        T,
  output logic [7:0]        D,
  output logic              running,
  output logic              ien,
  output logic              int_cycle,
  output logic              ld_ar,
  output logic              inr_ar,
  output logic              clr_ar,
  output logic              ld_pc,
  output logic              inr_pc,
  output logic              clr_pc,
  output logic              ld_dr,
  output logic              inr_dr,
  output logic              ld_ir,
  output logic              ld_tr,
  output logic              ld_ac,
  output logic              clr_ac,
  output logic              read_ram,
  output logic              write_ram,
  output logic              and_op,
  output logic              add_op,
  output logic              lda_op,
  output logic              cma,
  output logic              cla,
  output logic              cir,
  output logic              cil,
  output logic [2:0]        bus_sel
);
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_M    = 3'd7;

  logic [2:0] sc;
  logic [2:0] op;
  logic [4:0] b;
  logic       i_bit;
  logic       clr_sc;
  logic       hlt;
  logic       ien_set;
  logic       ien_clr;
  logic       r_clr;
  logic       set_r;
  logic       unused_addr;

  assign i_bit       = ir[ADDR_W+3];
  assign op          = ir[ADDR_W+2:ADDR_W];
  assign b           = ir[4:0];
  assign unused_addr = ^(ir[ADDR_W-1:0] >> 5);
  assign T           = running ? 8'b1 << sc : 8'b0;
  assign D           = 8'b1 << op;
  // an interrupt is only accepted once the current instruction is past fetch
  assign set_r       = running & (sc >= 3'd3) & ien & (fgi | fgo);

  // sequence counter, run flag, interrupt enable and interrupt-cycle flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc        <= 3'd0;
      running   <= RUN_ON_RESET;
      ien       <= 1'b0;
      int_cycle <= 1'b0;
    end else begin
      sc        <= clr_sc ? 3'd0 : running ? sc + 3'd1 : sc;
      running   <= ~hlt & (running | start);
      ien       <= ien_clr ? 1'b0 : ien_set ? 1'b1 : ien;
      int_cycle <= r_clr ? 1'b0 : set_r ? 1'b1 : int_cycle;
    end
  end

  // decode SC/R/IR into register, RAM, ALU and bus strobes
  always_comb begin
    {ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc, ld_dr, inr_dr, ld_ir, ld_tr} = '0;
    {ld_ac, clr_ac, read_ram, write_ram, and_op, add_op, lda_op, cma, cla, cir, cil} = '0;
    bus_sel = BUS_NONE;
    clr_sc  = 1'b0;
    hlt     = 1'b0;
    ien_set = 1'b0;
    ien_clr = 1'b0;
    r_clr   = 1'b0;
    if (running) begin
      if (int_cycle && sc <= 3'd2) begin
        clr_ar    = sc == 3'd0;
        ld_tr     = sc == 3'd0;
        write_ram = sc == 3'd1;
        clr_pc    = sc == 3'd1;
        inr_pc    = sc == 3'd2;
        clr_sc    = sc == 3'd2;
        ien_clr   = sc == 3'd2;
        r_clr     = sc == 3'd2;
        bus_sel   = sc == 3'd0 ? BUS_PC : sc == 3'd1 ? BUS_TR : BUS_NONE;
      end else begin
        case (sc)
          3'd0: begin
            bus_sel = BUS_PC;
            ld_ar   = 1'b1;
          end
          3'd1: begin
            bus_sel  = BUS_M;
            read_ram = 1'b1;
            ld_ir    = 1'b1;
            inr_pc   = 1'b1;
          end
          3'd2: begin
            bus_sel = BUS_IR;
            ld_ar   = 1'b1;
          end
          3'd3: begin
            if (D[7]) begin
              clr_sc = 1'b1;
              if (i_bit) begin
                ien_set = b[0];
                ien_clr = b[1];
              end else begin
                cla    = b[3];
                clr_ac = b[3];
                cma    = b[2];
                cir    = b[1];
                cil    = b[0];
                ld_ac  = |b[2:0];
                hlt    = b[4];
              end
            end else if (i_bit) begin
              bus_sel  = BUS_M;
              read_ram = 1'b1;
              ld_ar    = 1'b1;
            end
          end
          3'd4: begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd6: begin
                bus_sel  = BUS_M;
                read_ram = 1'b1;
                ld_dr    = 1'b1;
              end
              3'd3: begin
                bus_sel   = BUS_AC;
                write_ram = 1'b1;
                clr_sc    = 1'b1;
              end
              3'd4: begin
                bus_sel = BUS_AR;
                ld_pc   = 1'b1;
                clr_sc  = 1'b1;
              end
              3'd5: begin
                bus_sel   = BUS_PC;
                write_ram = 1'b1;
                inr_ar    = 1'b1;
              end
              default: clr_sc = 1'b1;
            endcase
          end
          3'd5: begin
            case (op)
              3'd0, 3'd1, 3'd2: begin
                and_op = op == 3'd0;
                add_op = op == 3'd1;
                lda_op = op == 3'd2;
                ld_ac  = 1'b1;
                clr_sc = 1'b1;
              end
              3'd5: begin
                bus_sel = BUS_AR;
                ld_pc   = 1'b1;
                clr_sc  = 1'b1;
              end
              3'd6: inr_dr = 1'b1;
              default: clr_sc = 1'b1;
            endcase
          end
          3'd6: begin
            clr_sc = 1'b1;
            if (op == 3'd6) begin
              bus_sel   = BUS_DR;
              write_ram = 1'b1;
              inr_pc    = dr_zero;
            end
          end
          default: clr_sc = 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_basic_sequencer.sv
// tb_basic_sequencer: scoreboard bench for the basic accumulator sequencer
module tb_basic_sequencer;
  localparam logic [20:0] LD_AR  = 21'h100000;
  localparam logic [20:0] INR_AR = 21'h080000;
  localparam logic [20:0] CLR_AR = 21'h040000;
  localparam logic [20:0] LD_PC  = 21'h020000;
  localparam logic [20:0] INR_PC = 21'h010000;
  localparam logic [20:0] CLR_PC = 21'h008000;
  localparam logic [20:0] LD_DR  = 21'h004000;
  localparam logic [20:0] INR_DR = 21'h002000;
  localparam logic [20:0] LD_IR  = 21'h001000;
  localparam logic [20:0] LD_TR  = 21'h000800;
  localparam logic [20:0] LD_AC  = 21'h000400;
  localparam logic [20:0] CLR_AC = 21'h000200;
  localparam logic [20:0] RD     = 21'h000100;
  localparam logic [20:0] WR     = 21'h000080;
  localparam logic [20:0] AND_OP = 21'h000040;
  localparam logic [20:0] ADD_OP = 21'h000020;
  localparam logic [20:0] LDA_OP = 21'h000010;
  localparam logic [20:0] CMA    = 21'h000008;
  localparam logic [20:0] CLA    = 21'h000004;
  localparam logic [20:0] CIR    = 21'h000002;
  localparam logic [20:0] CIL    = 21'h000001;

  typedef struct {
    string       nm;
    logic [7:0]  t;
    logic [7:0]  d;
    logic [20:0] s;
    logic [2:0]  b;
    logic        run;
    logic        ie;
    logic        r;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, dr_zero, fgi, fgo;
  logic [9:0] ir;
  logic [7:0] T, D;
  logic running, ien, int_cycle;
  logic ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc, ld_dr, inr_dr, ld_ir, ld_tr;
  logic ld_ac, clr_ac, read_ram, write_ram, and_op, add_op, lda_op, cma, cla, cir, cil;
  logic [2:0] bus_sel;
  logic [20:0] st;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  basic_sequencer #(.ADDR_W(6), .RUN_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .dr_zero(dr_zero), .fgi(fgi), .fgo(fgo),
    .T(T), .D(D), .running(running), .ien(ien), .int_cycle(int_cycle),
    .ld_ar(ld_ar), .inr_ar(inr_ar), .clr_ar(clr_ar), .ld_pc(ld_pc), .inr_pc(inr_pc),
    .clr_pc(clr_pc), .ld_dr(ld_dr), .inr_dr(inr_dr), .ld_ir(ld_ir), .ld_tr(ld_tr),
    .ld_ac(ld_ac), .clr_ac(clr_ac), .read_ram(read_ram), .write_ram(write_ram),
    .and_op(and_op), .add_op(add_op), .lda_op(lda_op), .cma(cma), .cla(cla), .cir(cir),
    .cil(cil), .bus_sel(bus_sel)
  );

  always #5 clk = ~clk;

  assign st = {ld_ar, inr_ar, clr_ar, ld_pc, inr_pc, clr_pc, ld_dr, inr_dr, ld_ir, ld_tr,
               ld_ac, clr_ac, read_ram, write_ram, and_op, add_op, lda_op, cma, cla, cir, cil};

  // monitor: every falling edge with a pending expectation is one comparison
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({T, D, st, bus_sel, running, ien, int_cycle} !== {e.t, e.d, e.s, e.b, e.run, e.ie, e.r}) begin
        errors++;
        $display("FAIL %s: got T=%h D=%h strobes=%h bus=%0d run=%b ien=%b r=%b, want T=%h D=%h strobes=%h bus=%0d run=%b ien=%b r=%b",
                 e.nm, T, D, st, bus_sel, running, ien, int_cycle, e.t, e.d, e.s, e.b, e.run, e.ie, e.r);
      end
    end
  end

  task automatic step(input string nm, input logic [7:0] t, input logic [20:0] s, input logic [2:0] b,
                      input logic run, input logic ie, input logic r);
    exp_t e;
    e.nm  = nm;
    e.t   = t;
    e.d   = 8'b1 << ir[8:6];
    e.s   = s;
    e.b   = b;
    e.run = run;
    e.ie  = ie;
    e.r   = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string nm, input logic ie);
    step({nm, "_t0"}, 8'h01, LD_AR, 3'd2, 1'b1, ie, 1'b0);
    step({nm, "_t1"}, 8'h02, RD | LD_IR | INR_PC, 3'd7, 1'b1, ie, 1'b0);
    step({nm, "_t2"}, 8'h04, LD_AR, 3'd5, 1'b1, ie, 1'b0);
  endtask

  task automatic ion_instr(input string nm, input logic ie);
    ir = 10'b1_111_000001;
    fetch(nm, ie);
    step({nm, "_t3"}, 8'h08, '0, 3'd0, 1'b1, ie, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dr_zero = 1'b0; fgi = 1'b0; fgo = 1'b0;
    ir = 10'b0_001_000101;
    @(posedge clk);
    #1;
    step("rst", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step("idle", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("idle2", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("start_cyc", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    fetch("add", 1'b0);
    step("add_t3", 8'h08, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("add_t4", 8'h10, RD | LD_DR, 3'd7, 1'b1, 1'b0, 1'b0);
    step("add_t5", 8'h20, ADD_OP | LD_AC, 3'd0, 1'b1, 1'b0, 1'b0);
    ir = 10'b1_000_000011;
    fetch("andi", 1'b0);
    step("andi_t3", 8'h08, RD | LD_AR, 3'd7, 1'b1, 1'b0, 1'b0);
    step("andi_t4", 8'h10, RD | LD_DR, 3'd7, 1'b1, 1'b0, 1'b0);
    step("andi_t5", 8'h20, AND_OP | LD_AC, 3'd0, 1'b1, 1'b0, 1'b0);
    ir = 10'b0_100_000001;
    fetch("bun", 1'b0);
    step("bun_t3", 8'h08, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("bun_t4", 8'h10, LD_PC, 3'd1, 1'b1, 1'b0, 1'b0);
    ir = 10'b0_101_000001;
    fetch("bsa", 1'b0);
    step("bsa_t3", 8'h08, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("bsa_t4", 8'h10, WR | INR_AR, 3'd2, 1'b1, 1'b0, 1'b0);
    step("bsa_t5", 8'h20, LD_PC, 3'd1, 1'b1, 1'b0, 1'b0);
    ir = 10'b0_110_000000;
    dr_zero = 1'b1;
    fetch("isz1", 1'b0);
    step("isz1_t3", 8'h08, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("isz1_t4", 8'h10, RD | LD_DR, 3'd7, 1'b1, 1'b0, 1'b0);
    step("isz1_t5", 8'h20, INR_DR, 3'd0, 1'b1, 1'b0, 1'b0);
    step("isz1_t6", 8'h40, WR | INR_PC, 3'd3, 1'b1, 1'b0, 1'b0);
    dr_zero = 1'b0;
    fetch("isz0", 1'b0);
    step("isz0_t3", 8'h08, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("isz0_t4", 8'h10, RD | LD_DR, 3'd7, 1'b1, 1'b0, 1'b0);
    step("isz0_t5", 8'h20, INR_DR, 3'd0, 1'b1, 1'b0, 1'b0);
    step("isz0_t6", 8'h40, WR, 3'd3, 1'b1, 1'b0, 1'b0);
    ir = 10'b0_111_000101;
    fetch("cmacil", 1'b0);
    step("cmacil_t3", 8'h08, CMA | CIL | LD_AC, 3'd0, 1'b1, 1'b0, 1'b0);
    ir = 10'b0_111_010000;
    fetch("hlt", 1'b0);
    start = 1'b1;
    step("hlt_t3", 8'h08, '0, 3'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("halted", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("halted2", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("restart", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    ion_instr("ion", 1'b0);
    ir = 10'b1_111_000011;
    fetch("ionof", 1'b1);
    step("ionof_t3", 8'h08, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    ion_instr("ion2", 1'b0);
    ir = 10'b0_011_000111;
    fetch("sta", 1'b1);
    step("sta_t3", 8'h08, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    fgi = 1'b1;
    step("sta_t4", 8'h10, WR, 3'd4, 1'b1, 1'b1, 1'b0);
    fgi = 1'b0;
    step("rt0", 8'h01, CLR_AR | LD_TR, 3'd2, 1'b1, 1'b1, 1'b1);
    step("rt1", 8'h02, WR | CLR_PC, 3'd6, 1'b1, 1'b1, 1'b1);
    step("rt2", 8'h04, INR_PC, 3'd0, 1'b1, 1'b1, 1'b1);
    ion_instr("ion3", 1'b0);
    ir = 10'b0_111_010000;
    fetch("hltr", 1'b1);
    fgo = 1'b1;
    step("hltr_t3", 8'h08, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    fgo = 1'b0;
    step("hltr_idle", 8'h00, '0, 3'd0, 1'b0, 1'b1, 1'b1);
    start = 1'b1;
    step("hltr_start", 8'h00, '0, 3'd0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step("hltr_rt0", 8'h01, CLR_AR | LD_TR, 3'd2, 1'b1, 1'b1, 1'b1);
    step("hltr_rt1", 8'h02, WR | CLR_PC, 3'd6, 1'b1, 1'b1, 1'b1);
    step("hltr_rt2", 8'h04, INR_PC, 3'd0, 1'b1, 1'b1, 1'b1);
    ion_instr("ion4", 1'b0);
    ir = 10'b0_110_000000;
    fetch("iszr", 1'b1);
    step("iszr_t3", 8'h08, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    step("iszr_t4", 8'h10, RD | LD_DR, 3'd7, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    step("async_rst", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step("post_rst", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("post_rst2", 8'h00, '0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
